// File: rtl/peridot_cam_capture.sv
// Camera byte capture: crops a frame to a word-aligned window and writes it to an 8-to-32 FIFO.
// Latency: one cycle from camera sample to fifo_wrreq. Backpressure: a byte arriving on fifo_full is dropped and overflow is set.
module peridot_cam_capture #(
  parameter int HCOUNT_W = 12,
  parameter int VCOUNT_W = 11
) (
  input  logic                csi_global_clk,
  input  logic                csi_global_reset_n,
  input  logic [7:0]          cam_data,
  input  logic                cam_href,
  input  logic                cam_vsync,
  input  logic                start,
  input  logic                abort,
  input  logic [HCOUNT_W-1:0] hstart,
  input  logic [HCOUNT_W-1:0] hsize,
  input  logic [VCOUNT_W-1:0] vstart,
  input  logic [VCOUNT_W-1:0] vsize,
  input  logic                fifo_full,
  output logic                fifo_wrreq,
  output logic [7:0]          fifo_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                short_frame
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_DONE} state_t;

  localparam logic [HCOUNT_W-1:0] HMASK = ~HCOUNT_W'(3);

  state_t r_state, w_next;

  logic                r_hist_vld, r_href_d, r_vsync_d, r_seen_rise;
  logic [HCOUNT_W-1:0] r_hcount, r_hstart, r_hsize;
  logic [VCOUNT_W-1:0] r_vcount, r_vstart, r_vsize;
  logic                r_wrreq, r_overflow, r_short;
  logic [7:0]          r_data;

  logic                w_vs_rise, w_vs_fall, w_href_fall;
  logic [HCOUNT_W:0]   w_hend;
  logic [VCOUNT_W:0]   w_vend;
  logic [HCOUNT_W-1:0] w_hcount_inc;
  logic [VCOUNT_W-1:0] w_vcount_inc;
  logic                w_in_win, w_frame_end, w_sample, w_accept;

  // History is only trusted once it holds a real sample, so the first cycle after reset sees no edge.
  assign w_vs_rise   = r_hist_vld &&  cam_vsync && !r_vsync_d;
  assign w_vs_fall   = r_hist_vld && !cam_vsync &&  r_vsync_d;
  assign w_href_fall = r_hist_vld && !cam_href  &&  r_href_d;

  assign w_hend       = {1'b0, r_hstart} + {1'b0, r_hsize};
  assign w_vend       = {1'b0, r_vstart} + {1'b0, r_vsize};
  assign w_hcount_inc = (&r_hcount) ? r_hcount : r_hcount + HCOUNT_W'(1);
  assign w_vcount_inc = (&r_vcount) ? r_vcount : r_vcount + VCOUNT_W'(1);

  assign w_in_win = (r_hcount >= r_hstart) && ({1'b0, r_hcount} < w_hend) &&
                    (r_vcount >= r_vstart) && ({1'b0, r_vcount} < w_vend);

  assign w_frame_end = w_href_fall && ({1'b0, w_vcount_inc} == w_vend);
  assign w_sample    = (r_state == S_ACTIVE) && cam_href && w_in_win && !abort;
  assign w_accept    = start && !abort;

  always_ff @(posedge csi_global_clk or negedge csi_global_reset_n) begin
    if (!csi_global_reset_n) r_state <= S_IDLE;
    else                     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SYNC;
      S_SYNC: begin
        if (abort)                         w_next = S_IDLE;
        else if (r_seen_rise && w_vs_fall) w_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (abort)                          w_next = S_IDLE;
        else if (w_frame_end || w_vs_rise)  w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge csi_global_clk or negedge csi_global_reset_n) begin
    if (!csi_global_reset_n) begin
      r_hist_vld  <= 1'b0;
      r_href_d    <= 1'b0;
      r_vsync_d   <= 1'b0;
      r_seen_rise <= 1'b0;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_hstart    <= '0;
      r_hsize     <= '0;
      r_vstart    <= '0;
      r_vsize     <= '0;
      r_wrreq     <= 1'b0;
      r_data      <= '0;
      r_overflow  <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_hist_vld <= 1'b1;
      r_href_d   <= cam_href;
      r_vsync_d  <= cam_vsync;
      r_wrreq    <= w_sample && !fifo_full;
      if (w_sample && !fifo_full) r_data <= cam_data;

      case (r_state)
        S_IDLE: begin
          r_seen_rise <= 1'b0;
          if (w_accept) begin
            r_hstart   <= hstart & HMASK;
            r_hsize    <= hsize & HMASK;
            r_vstart   <= vstart;
            r_vsize    <= vsize;
            r_overflow <= 1'b0;
            r_short    <= 1'b0;
          end
        end
        S_SYNC: begin
          if (w_vs_rise) r_seen_rise <= 1'b1;
          if (w_next == S_ACTIVE) begin
            r_hcount <= '0;
            r_vcount <= '0;
          end
        end
        S_ACTIVE: begin
          if (w_sample && fifo_full) r_overflow <= 1'b1;
          if (cam_href) begin
            r_hcount <= w_hcount_inc;
          end else if (w_href_fall) begin
            r_hcount <= '0;
            r_vcount <= w_vcount_inc;
          end
          // A completed last line takes precedence over a coincident vsync rise.
          if (!abort && !w_frame_end && w_vs_rise) r_short <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_wrreq  = r_wrreq;
  assign fifo_data   = r_data;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign overflow    = r_overflow;
  assign short_frame = r_short;

endmodule

// File: doc/peridot_cam_capture.md
PERIDOT_CAM_CAPTURE -- requirements
Module: peridot_cam_capture

Interface
REQ-001 Parameter HCOUNT_W, default 12, width of byte-in-line counter and window fields.
REQ-002 Parameter VCOUNT_W, default 11, width of line counter and window fields.
REQ-003 csi_global_clk  in  1  cam_clk domain clock; all logic on rising edge; one clock only.
REQ-004 csi_global_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cam_data  in  8  registered camera byte.
REQ-006 cam_href  in  1  registered line-valid, high while bytes are valid.
REQ-007 cam_vsync  in  1  registered frame sync, high during vertical blanking.
REQ-008 start  in  1  one-cycle pulse, arms capture of next full frame.
REQ-009 abort  in  1  one-cycle pulse, cancels capture.
REQ-010 hstart, hsize  in  HCOUNT_W each  window first byte and byte count per line.
REQ-011 vstart, vsize  in  VCOUNT_W each  window first line and line count.
REQ-012 fifo_full  in  1  downstream 8-to-32 FIFO full.
REQ-013 fifo_wrreq  out  1  write strobe to FIFO.
REQ-014 fifo_data  out  8  byte to FIFO.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse at frame completion.
REQ-017 overflow  out  1  sticky, byte dropped on fifo_full.
REQ-018 short_frame  out  1  sticky, frame ended before vsize lines.

Function
REQ-019 States IDLE, SYNC, ACTIVE, DONE; encoding free.
REQ-020 Window fields latched on start accepted in IDLE; hsize[1:0] and hstart[1:0] treated as 0 (32-bit word alignment).
REQ-021 IDLE: start -> SYNC; clears overflow and short_frame; start in other states ignored.
REQ-022 SYNC: wait for cam_vsync rising edge, then falling edge -> ACTIVE; vcount and hcount cleared on entry to ACTIVE.
REQ-023 ACTIVE: hcount increments each cycle cam_href=1, clears on href falling edge; vcount increments on href falling edge.
REQ-024 Counters saturate at all-ones, never wrap.
REQ-025 Byte in window when hstart <= hcount < hstart+hsize and vstart <= vcount < vstart+vsize; sums computed at HCOUNT_W+1/VCOUNT_W+1 bits, no overflow.
REQ-026 In-window byte with fifo_full=0: fifo_wrreq=1 and fifo_data=cam_data exactly one cycle after the sample cycle.
REQ-027 In-window byte with fifo_full=1: fifo_wrreq=0, byte dropped, overflow set next cycle.
REQ-028 ACTIVE -> DONE on href falling edge making vcount = vstart+vsize.
REQ-029 ACTIVE -> DONE on cam_vsync rising edge before that; short_frame set.
REQ-030 DONE: done=1 for one cycle, next state IDLE.
REQ-031 abort in SYNC/ACTIVE/DONE -> IDLE next cycle, fifo_wrreq=0 from that cycle, no done; abort and start same cycle in IDLE: abort wins, stays IDLE.
REQ-032 hsize=0 or vsize=0: no writes; frame completes via REQ-028 at line vstart, or REQ-029.
REQ-033 Edge detection uses one internal history register per input; first cycle after reset has no edge.

Reset
REQ-034 On csi_global_reset_n=0: state IDLE; fifo_wrreq, done, busy, overflow, short_frame = 0; fifo_data = 0; counters and edge history = 0.
REQ-035 Reset mid-frame: outputs go to reset values immediately (asynchronous), no done pulse; release resumes in IDLE.

Verification
REQ-036 Window hstart=4, hsize=8, vstart=1, vsize=2 on 4-line frame of 16-byte lines -> exactly 16 wrreq, bytes 4..11 of lines 1-2, done once after line-2 href fall.
REQ-037 start mid-frame (vsync low) -> no writes until after next vsync high-then-low.
REQ-038 fifo_full held 3 cycles during window -> 3 bytes missing, overflow=1, done still pulses; next start clears overflow.
REQ-039 vsize=10, vsync rises after 6 lines -> done pulse, short_frame=1.
REQ-040 abort in ACTIVE -> wrreq=0 next cycle, busy=0, no done; reset asserted in ACTIVE -> all outputs 0 asynchronously.
REQ-041 hstart=5, hsize=10 -> treated as hstart=4, hsize=8; 8 bytes per line.
